// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between the CPU (0) and the loader (1).
// Every output is registered. A requester is masked for the cycle its ack is high.
module ram_arbiter #(
    parameter int g_RAM_WIDTH = 11,
    parameter int g_RAM_ADDR  = 9
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_req0,
    input  logic                   i_we0,
    input  logic [g_RAM_ADDR-1:0]  i_addr0,
    input  logic [g_RAM_WIDTH-1:0] i_wdata0,
    input  logic                   i_req1,
    input  logic                   i_we1,
    input  logic [g_RAM_ADDR-1:0]  i_addr1,
    input  logic [g_RAM_WIDTH-1:0] i_wdata1,
    output logic                   o_ack0,
    output logic                   o_ack1,
    output logic [g_RAM_WIDTH-1:0] o_rdata0,
    output logic [g_RAM_WIDTH-1:0] o_rdata1,
    output logic                   o_ram_en,
    output logic                   o_ram_we,
    output logic                   o_ram_re,
    output logic [g_RAM_ADDR-1:0]  o_ram_addr,
    output logic [g_RAM_WIDTH-1:0] o_ram_data,
    input  logic [g_RAM_WIDTH-1:0] i_ram_data,
    output logic [1:0]             o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RDATA  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   id_q, id_d;
    logic                   we_q, we_d;
    logic [g_RAM_ADDR-1:0]  addr_q, addr_d;
    logic [g_RAM_WIDTH-1:0] wdata_q, wdata_d;
    logic                   en_q, en_d;
    logic                   ram_we_q, ram_we_d;
    logic                   re_q, re_d;
    logic                   ack0_q, ack0_d;
    logic                   ack1_q, ack1_d;
    logic [g_RAM_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [g_RAM_WIDTH-1:0] rdata1_q, rdata1_d;

    logic                   elig0, elig1, gnt_id;
    logic                   gnt_we;
    logic [g_RAM_ADDR-1:0]  gnt_addr;
    logic [g_RAM_WIDTH-1:0] gnt_wdata;

    // A requester whose ack is high right now is not eligible; the other one wins the tie-free case.
    assign elig0     = i_req0 & ~ack0_q;
    assign elig1     = i_req1 & ~ack1_q;
    assign gnt_id    = (elig0 & elig1) ? ~last_grant_q : elig1;
    assign gnt_we    = gnt_id ? i_we1    : i_we0;
    assign gnt_addr  = gnt_id ? i_addr1  : i_addr0;
    assign gnt_wdata = gnt_id ? i_wdata1 : i_wdata0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            en_q         <= 1'b0;
            ram_we_q     <= 1'b0;
            re_q         <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            en_q         <= en_d;
            ram_we_q     <= ram_we_d;
            re_q         <= re_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        en_d         = 1'b0;
        ram_we_d     = 1'b0;
        re_d         = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            S_IDLE: begin
                if (elig0 | elig1) begin
                    // Strobes are registered here so they are high during the ACCESS cycle.
                    id_d         = gnt_id;
                    last_grant_d = gnt_id;
                    we_d         = gnt_we;
                    addr_d       = gnt_addr;
                    wdata_d      = gnt_wdata;
                    en_d         = 1'b1;
                    ram_we_d     = gnt_we;
                    re_d         = ~gnt_we;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    ack0_d  = ~id_q;
                    ack1_d  = id_q;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                if (id_q) begin
                    rdata1_d = i_ram_data;
                end else begin
                    rdata0_d = i_ram_data;
                end
                ack0_d  = ~id_q;
                ack1_d  = id_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_ack0      = ack0_q;
    assign o_ack1      = ack1_q;
    assign o_rdata0    = rdata0_q;
    assign o_rdata1    = rdata1_q;
    assign o_ram_en    = en_q;
    assign o_ram_we    = ram_we_q;
    assign o_ram_re    = re_q;
    assign o_ram_addr  = addr_q;
    assign o_ram_data  = wdata_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM attached to the RAM pins.
module tb_ram_arbiter;

    localparam int W = 11;
    localparam int A = 9;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0, we0, req1, we1;
    logic [A-1:0] addr0, addr1;
    logic [W-1:0] wdata0, wdata1;
    logic         ack0, ack1;
    logic [W-1:0] rdata0, rdata1;
    logic         ram_en, ram_we, ram_re;
    logic [A-1:0] ram_addr;
    logic [W-1:0] ram_wdata;
    logic [W-1:0] ram_q = '0;
    logic [1:0]   dbg_state;
    logic [W-1:0] mem [0:(1<<A)-1] = '{default: '0};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.g_RAM_WIDTH(W), .g_RAM_ADDR(A)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
        .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
        .o_ack0(ack0), .o_ack1(ack1), .o_rdata0(rdata0), .o_rdata1(rdata1),
        .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_re(ram_re),
        .o_ram_addr(ram_addr), .o_ram_data(ram_wdata), .i_ram_data(ram_q),
        .o_dbg_state(dbg_state)
    );

    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_en && ram_re) ram_q <= mem[ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        step();
        step();
        checks++;
        if ({ack0, ack1, ram_en, ram_we, ram_re} !== 5'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_init: ack/strobes=%b state=%0d, required 00000 state 0",
                     {ack0, ack1, ram_en, ram_we, ram_re}, dbg_state);
        end
        rst_n = 1'b1;
        step();
        req0 = 1; we0 = 1; addr0 = 9'h1FF; wdata0 = 11'h7FF;
        step();
        checks++;
        if (ram_en !== 1'b1 || ram_addr !== 9'h1FF || ram_wdata !== 11'h7FF) begin
            errors++;
            $display("FAIL reset_pre_access: en=%b addr=%h data=%h, required 1 1ff 7ff",
                     ram_en, ram_addr, ram_wdata);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack0, ack1, ram_en, ram_we, ram_re} !== 5'b0 || ram_addr !== '0 ||
            ram_wdata !== '0 || rdata0 !== '0 || rdata1 !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_async: flags=%b addr=%h data=%h rd0=%h rd1=%h state=%0d, required all 0",
                     {ack0, ack1, ram_en, ram_we, ram_re}, ram_addr, ram_wdata, rdata0, rdata1, dbg_state);
        end
        req0 = 0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({ack0, ack1, ram_en} !== 3'b0 || dbg_state !== 2'd0) begin
                errors++;
                $display("FAIL reset_quiet c%0d: ack0/ack1/en=%b state=%0d, required 000 state 0",
                         c, {ack0, ack1, ram_en}, dbg_state);
            end
        end
        checks++;
        if (mem[9'h1FF] !== 11'h000) begin
            errors++;
            $display("FAIL reset_abort_write: mem[1ff]=%h, required 000", mem[9'h1FF]);
        end
    endtask

    task automatic test_single_write();
        req0 = 1; we0 = 1; addr0 = 9'h005; wdata0 = 11'h155;
        step();
        checks++;
        if ({ram_en, ram_we, ram_re} !== 3'b110 || ram_addr !== 9'h005 || ram_wdata !== 11'h155 ||
            ack0 !== 1'b0 || ack1 !== 1'b0) begin
            errors++;
            $display("FAIL write_c1: en/we/re=%b addr=%h data=%h ack0=%b ack1=%b, required 110 005 155 0 0",
                     {ram_en, ram_we, ram_re}, ram_addr, ram_wdata, ack0, ack1);
        end
        step();
        checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || ram_en !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL write_c2: ack0=%b ack1=%b en=%b state=%0d, required 1 0 0 0",
                     ack0, ack1, ram_en, dbg_state);
        end
        req0 = 0;
        step();
        checks++;
        if (ack0 !== 1'b0 || ack1 !== 1'b0 || mem[9'h005] !== 11'h155) begin
            errors++;
            $display("FAIL write_c3: ack0=%b ack1=%b mem[005]=%h, required 0 0 155", ack0, ack1, mem[9'h005]);
        end
    endtask

    task automatic test_single_read();
        req1 = 1; we1 = 0; addr1 = 9'h005; wdata1 = '0;
        step();
        checks++;
        if ({ram_en, ram_we, ram_re} !== 3'b101 || ram_addr !== 9'h005) begin
            errors++;
            $display("FAIL read_c1: en/we/re=%b addr=%h, required 101 005", {ram_en, ram_we, ram_re}, ram_addr);
        end
        step();
        checks++;
        if (ram_en !== 1'b0 || ack1 !== 1'b0 || dbg_state !== 2'd2) begin
            errors++;
            $display("FAIL read_c2: en=%b ack1=%b state=%0d, required 0 0 2", ram_en, ack1, dbg_state);
        end
        step();
        checks++;
        if (ack1 !== 1'b1 || ack0 !== 1'b0 || rdata1 !== 11'h155) begin
            errors++;
            $display("FAIL read_c3: ack1=%b ack0=%b rdata1=%h, required 1 0 155", ack1, ack0, rdata1);
        end
        req1 = 0;
        step();
        checks++;
        if (ack1 !== 1'b0 || rdata1 !== 11'h155) begin
            errors++;
            $display("FAIL read_hold: ack1=%b rdata1=%h, required 0 155", ack1, rdata1);
        end
    endtask

    task automatic test_tie();
        logic exp_en, exp_a0, exp_a1;
        logic [A-1:0] exp_addr;
        do_reset();
        req0 = 1; we0 = 1; addr0 = 9'h001; wdata0 = 11'h0AA;
        req1 = 1; we1 = 1; addr1 = 9'h002; wdata1 = 11'h0BB;
        for (int c = 1; c <= 9; c++) begin
            step();
            exp_en   = (c % 2 == 1) && (c <= 7);
            exp_addr = (c == 1 || c == 5) ? 9'h001 : 9'h002;
            exp_a0   = (c == 2 || c == 6);
            exp_a1   = (c == 4 || c == 8);
            checks++;
            if (ram_en !== exp_en || ack0 !== exp_a0 || ack1 !== exp_a1 ||
                (exp_en && ram_addr !== exp_addr)) begin
                errors++;
                $display("FAIL tie_c%0d: en=%b ack0=%b ack1=%b addr=%h, required %b %b %b %h",
                         c, ram_en, ack0, ack1, ram_addr, exp_en, exp_a0, exp_a1, exp_addr);
            end
            if (c == 8) begin
                req0 = 0;
                req1 = 0;
            end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        int en_count;
        logic exp_en, exp_ack;
        en_count = 0;
        k = 0;
        req0 = 1; we0 = 1; addr0 = 9'h010; wdata0 = 11'h101;
        for (int c = 1; c <= 9; c++) begin
            step();
            exp_en  = (c == 1 || c == 4 || c == 7);
            exp_ack = (c == 2 || c == 5 || c == 8);
            if (ram_en === 1'b1) en_count++;
            checks++;
            if (ram_en !== exp_en || ack0 !== exp_ack || ack1 !== 1'b0 ||
                (exp_en && (ram_addr !== 9'(9'h010 + k) || ram_wdata !== 11'(11'h101 + k)))) begin
                errors++;
                $display("FAIL b2b_c%0d: en=%b ack0=%b ack1=%b addr=%h data=%h, required %b %b 0 %h %h",
                         c, ram_en, ack0, ack1, ram_addr, ram_wdata, exp_en, exp_ack,
                         9'(9'h010 + k), 11'(11'h101 + k));
            end
            if (exp_ack) begin
                k++;
                addr0  = 9'(9'h010 + k);
                wdata0 = 11'(11'h101 + k);
                if (c == 8) req0 = 0;
            end
        end
        checks++;
        if (en_count != 3) begin
            errors++;
            $display("FAIL b2b_count: accesses=%0d, required 3", en_count);
        end
    endtask

    task automatic test_reset_during_read();
        req0 = 1; we0 = 0; addr0 = 9'h005;
        step();
        step();
        step();
        checks++;
        if (ack0 !== 1'b1 || rdata0 !== 11'h155) begin
            errors++;
            $display("FAIL rdr_first: ack0=%b rdata0=%h, required 1 155", ack0, rdata0);
        end
        req0 = 0;
        step();
        req0 = 1;
        step();
        step();
        checks++;
        if (dbg_state !== 2'd2) begin
            errors++;
            $display("FAIL rdr_in_rdata: state=%0d, required 2", dbg_state);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ack0 !== 1'b0 || rdata0 !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL rdr_abort: ack0=%b rdata0=%h state=%0d, required 0 000 0", ack0, rdata0, dbg_state);
        end
        req0 = 0;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (ack0 !== 1'b0 || rdata0 !== '0) begin
            errors++;
            $display("FAIL rdr_no_ack: ack0=%b rdata0=%h, required 0 000", ack0, rdata0);
        end
        req0 = 1; we0 = 0; addr0 = 9'h011;
        step();
        checks++;
        if ({ram_en, ram_we, ram_re} !== 3'b101 || ram_addr !== 9'h011) begin
            errors++;
            $display("FAIL rdr_new_c1: en/we/re=%b addr=%h, required 101 011", {ram_en, ram_we, ram_re}, ram_addr);
        end
        step();
        checks++;
        if (ack0 !== 1'b0) begin
            errors++;
            $display("FAIL rdr_new_c2: ack0=%b, required 0", ack0);
        end
        step();
        checks++;
        if (ack0 !== 1'b1 || rdata0 !== 11'h102) begin
            errors++;
            $display("FAIL rdr_new_c3: ack0=%b rdata0=%h, required 1 102", ack0, rdata0);
        end
        req0 = 0;
        step();
        checks++;
        if (ack0 !== 1'b0 || rdata0 !== 11'h102) begin
            errors++;
            $display("FAIL rdr_new_hold: ack0=%b rdata0=%h, required 0 102", ack0, rdata0);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_tie();
        test_back_to_back();
        test_reset_during_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
